// File: rtl/sram_controller.sv
// Single-port 32-bit load/store front end for a 16-bit asynchronous SRAM.
// Each request becomes two half-word cycles (LOW, HIGH) and then two settle states. The pipeline is held until DONE.
module sram_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    WAIT1,
    WAIT2,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic        is_write_q, is_write_d;
  logic [16:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] read_data_q, read_data_d;

  logic        request;
  logic        access_phase;
  logic        drive_dq;
  logic [15:0] dq_out;

  // The SRAM is 256K half-words, so only word address bits [18:2] select a location.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[31:19], address[1:0]};

  assign request = rd_en | wr_en;

  // NOTE: every signal in this block gets a default first, so no path can leave a latch behind.
  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;

    unique case (state_q)
      IDLE: begin
        if (request) begin
          state_d    = LOW;
          is_write_d = wr_en;
          addr_d     = address[18:2];
          wdata_d    = write_data;
        end
      end
      LOW: begin
        state_d = HIGH;
        if (!is_write_q) read_data_d[15:0] = SRAM_DQ;
      end
      HIGH: begin
        state_d = WAIT1;
        if (!is_write_q) read_data_d[31:16] = SRAM_DQ;
      end
      WAIT1:   state_d = WAIT2;
      WAIT2:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      is_write_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
    end
  end

  // All SRAM controls are decoded from the registered state. Reset therefore releases the bus in the same cycle.
  assign access_phase = (state_q == LOW) || (state_q == HIGH);
  assign drive_dq     = is_write_q && access_phase;
  assign dq_out       = (state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0];

  always_comb begin
    SRAM_ADDR = 18'd0;
    if (state_q == LOW)  SRAM_ADDR = {addr_q, 1'b0};
    if (state_q == HIGH) SRAM_ADDR = {addr_q, 1'b1};
  end

  assign SRAM_DQ   = drive_dq ? dq_out : 16'hzzzz;
  assign SRAM_WE_N = ~drive_dq;
  assign SRAM_OE_N = drive_dq;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  assign ready     = (state_q == DONE) || ((state_q == IDLE) && !request);
  assign read_data = read_data_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller. A behavioural async SRAM sits on the half-word bus.
// Expected values are hand-computed from the access sequence.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_ub_n, sram_lb_n, sram_we_n, sram_ce_n, sram_oe_n;

  int n_tests = 0;
  int n_fail  = 0;

  sram_controller dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (sram_dq),
    .SRAM_ADDR  (sram_addr),
    .SRAM_UB_N  (sram_ub_n),
    .SRAM_LB_N  (sram_lb_n),
    .SRAM_WE_N  (sram_we_n),
    .SRAM_CE_N  (sram_ce_n),
    .SRAM_OE_N  (sram_oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Async SRAM: a write lands at the clock edge that ends a WE_N-low cycle, and a read drives DQ while OE_N is low.
  logic [15:0] mem [0:262143];
  logic        model_en;
  assign sram_dq = (model_en && !sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'hzzzz;
  always @(posedge clk) if (!sram_we_n && !sram_ce_n) mem[sram_addr] <= sram_dq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Per-cycle trace of one access, sampled on falling edges: index 0 is IDLE with the request and index 5 is DONE.
  logic [5:0]  rdy_v, we_v, oe_v;
  logic [17:0] addr_v [0:5];
  logic [31:0] rd_done;

  task automatic run_access(input logic wr, input logic rd, input logic [31:0] addr, input logic [31:0] wd);
    @(posedge clk); #1;
    wr_en = wr; rd_en = rd; address = addr; write_data = wd;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rdy_v[i]  = ready;
      we_v[i]   = sram_we_n;
      oe_v[i]   = sram_oe_n;
      addr_v[i] = sram_addr;
      rd_done   = read_data;
      if (i == 0) begin
        @(posedge clk); #1;
        // Scramble the inputs once the request is latched; the access must not notice.
        wr_en = 1'b0; rd_en = 1'b0; address = 32'hFFFF_FFFF; write_data = 32'h0;
      end
    end
  endtask

  logic [11:0] bb_v;
  logic [31:0] bb_rd5, bb_rd11;
  logic [17:0] addr_or;

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0; model_en = 1'b0;

    // Reset state
    #12;
    check("rst_ready",     {31'd0, ready}, 32'd1);
    check("rst_we_n",      {31'd0, sram_we_n}, 32'd1);
    check("rst_dq_z",      {31'd0, sram_dq === 16'hzzzz}, 32'd1);
    check("rst_read_data", read_data, 32'd0);
    check("rst_addr",      {14'd0, sram_addr}, 32'd0);
    check("rst_ce_ub_lb",  {29'd0, sram_ce_n, sram_ub_n, sram_lb_n}, 32'd0);
    rd_en = 1'b1; #1;
    check("rst_ready_req", {31'd0, ready}, 32'd0);
    rd_en = 1'b0;
    @(negedge clk); rst = 1'b1; model_en = 1'b1;

    // Write 0xDEADBEEF to byte address 0x10, which is SRAM words 8 and 9.
    run_access(1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
    check("wr_ready_pat", {26'd0, rdy_v}, 32'h20);
    check("wr_we_low",    {26'd0, we_v}, 32'h39);
    check("wr_addr_low",  {14'd0, addr_v[1]}, 32'd8);
    check("wr_addr_high", {14'd0, addr_v[2]}, 32'd9);
    check("wr_addr_wait", {14'd0, addr_v[3]}, 32'd0);
    check("wr_oe_n",      {26'd0, oe_v}, 32'h06);
    check("wr_mem8",      {16'd0, mem[8]}, 32'h0000_BEEF);
    check("wr_mem9",      {16'd0, mem[9]}, 32'h0000_DEAD);
    check("wr_rd_kept",   rd_done, 32'd0);
    model_en = 1'b0; #1;
    check("wr_dq_z_done", {31'd0, sram_dq === 16'hzzzz}, 32'd1);
    model_en = 1'b1;

    // Read back from the same address.
    run_access(1'b0, 1'b1, 32'h0000_0010, 32'h0);
    check("rd_data",      rd_done, 32'hDEAD_BEEF);
    check("rd_ready_pat", {26'd0, rdy_v}, 32'h20);
    check("rd_no_we",     {26'd0, we_v}, 32'h3F);
    check("rd_oe_low",    {26'd0, oe_v}, 32'h00);

    // Write and read through the wrap: 0x0008_0008 lands on SRAM words 4 and 5.
    run_access(1'b1, 1'b0, 32'h0008_0008, 32'h4444_3333);
    check("wrap_wr_lo", {16'd0, mem[4]}, 32'h3333);
    check("wrap_wr_hi", {16'd0, mem[5]}, 32'h4444);
    run_access(1'b0, 1'b1, 32'h0008_0008, 32'h0);
    check("wrap_addr_low",  {14'd0, addr_v[1]}, 32'd4);
    check("wrap_addr_high", {14'd0, addr_v[2]}, 32'd5);
    check("wrap_rd_data",   rd_done, 32'h4444_3333);

    // A simultaneous read and write request resolves to a write.
    run_access(1'b1, 1'b1, 32'h0000_0004, 32'h1234_5678);
    check("both_mem2",    {16'd0, mem[2]}, 32'h5678);
    check("both_mem3",    {16'd0, mem[3]}, 32'h1234);
    check("both_we_low",  {26'd0, we_v}, 32'h39);
    check("both_rd_kept", rd_done, 32'h4444_3333);

    // Back-to-back reads with rd_en held for 12 cycles.
    @(posedge clk); #1;
    rd_en = 1'b1; address = 32'h0000_0010;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bb_v[i] = ready;
      if (i == 5)  bb_rd5  = read_data;
      if (i == 11) bb_rd11 = read_data;
    end
    @(posedge clk); #1;
    rd_en = 1'b0;
    check("b2b_ready_pat", {20'd0, bb_v}, 32'h820);
    check("b2b_rd_first",  bb_rd5, 32'hDEAD_BEEF);
    check("b2b_rd_second", bb_rd11, 32'hDEAD_BEEF);

    // Assert reset while a write is in HIGH.
    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'h0000_0020; write_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    check("mid_we_low_pre", {31'd0, sram_we_n}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0; model_en = 1'b0; #1;
    check("mid_we_n",      {31'd0, sram_we_n}, 32'd1);
    check("mid_dq_z",      {31'd0, sram_dq === 16'hzzzz}, 32'd1);
    check("mid_ready",     {31'd0, ready}, 32'd1);
    check("mid_read_data", read_data, 32'd0);
    addr_or = sram_addr;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      addr_or = addr_or | sram_addr;
    end
    rst = 1'b1; model_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      addr_or = addr_or | sram_addr;
    end
    check("mid_no_addr", {14'd0, addr_or}, 32'd0);
    check("mid_partial", {16'd0, mem[16]}, 32'h0000_F00D);

    // After reset, the first request is taken on the first edge.
    run_access(1'b0, 1'b1, 32'h0000_0008, 32'h0);
    check("post_rst_ready_pat", {26'd0, rdy_v}, 32'h20);
    check("post_rst_rd_data",   rd_done, 32'h4444_3333);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  rising-edge clock shared with the pipeline.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: wr_en  input  1  32-bit store request from the MEM stage.
REQ-005 Port: rd_en  input  1  32-bit load request from the MEM stage.
REQ-006 Port: address  input  32  byte address, already rebased by the MEM stage. Only bits [18:2] are used.
REQ-007 Port: write_data  input  32  store data.
REQ-008 Port: read_data  output  32  load result, valid while ready=1 in DONE.
REQ-009 Port: ready  output  1  high = pipeline may advance; low = freeze all stage registers.
REQ-010 Port: SRAM_DQ  inout  16  SRAM data bus.
REQ-011 Port: SRAM_ADDR  output  18  SRAM half-word address.
REQ-012 Ports: SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N  output  1 each  active-low SRAM controls.

Function
REQ-013 The FSM SHALL have six states: IDLE, LOW, HIGH, WAIT1, WAIT2, DONE.
REQ-014 IDLE transitions:
- to LOW on the next edge if rd_en or wr_en is high;
- otherwise it stays in IDLE.
REQ-015 The sequence SHALL be LOW->HIGH->WAIT1->WAIT2->DONE->IDLE, one state per cycle, unconditional.
REQ-016 The request SHALL be latched at the IDLE->LOW edge: op (write if wr_en, else read), address[18:2] and write_data. Later input changes SHALL be ignored until IDLE is re-entered.
REQ-017 When wr_en and rd_en are both high, the operation SHALL be a write.
REQ-018 ready SHALL be combinational:
- 0 in IDLE with rd_en|wr_en=1;
- 0 in LOW, HIGH, WAIT1 and WAIT2;
- 1 in DONE;
- 1 in IDLE with no request.
REQ-019 Each access SHALL therefore freeze the pipeline for exactly 5 cycles and release it for 1 cycle (DONE). The pipeline advances at the edge leaving DONE.
REQ-020 DONE SHALL always return to IDLE, even if rd_en or wr_en is still high. The following request is taken from IDLE on the next cycle.
REQ-021 SRAM_ADDR SHALL be {addr_latched[18:2],1'b0} in LOW, {addr_latched[18:2],1'b1} in HIGH, and 18'd0 in all other states.
REQ-022 Write access:
- SRAM_WE_N=0 in LOW and HIGH, 1 in every other state;
- SRAM_DQ SHALL carry wdata[15:0] in LOW and wdata[31:16] in HIGH;
- SRAM_DQ SHALL be high-Z in all other states and during reads.
REQ-023 Read access:
- read_data[15:0] SHALL capture SRAM_DQ at the LOW->HIGH edge;
- read_data[31:16] SHALL capture SRAM_DQ at the HIGH->WAIT1 edge;
- read_data SHALL hold its value until the next read captures.
REQ-024 Writes SHALL NOT modify read_data.
REQ-025 SRAM_CE_N, SRAM_UB_N and SRAM_LB_N SHALL be constant 0. SRAM_OE_N SHALL be 1 during write LOW/HIGH and 0 otherwise.
REQ-026 Address wrap: bits above [18] SHALL be ignored, so 32'h0008_0000 maps to SRAM_ADDR 0.

Reset
REQ-027 While rst=0 (asynchronous):
- the state SHALL be IDLE and read_data 32'd0;
- the latched request SHALL be cleared;
- SRAM_WE_N=1 and SRAM_DQ high-Z;
- ready SHALL follow REQ-018 for IDLE.
REQ-028 A reset asserted mid-access SHALL abort the access immediately. A partially written word is permitted; no further SRAM cycles SHALL be issued.
REQ-029 After rst returns to 1, the first request SHALL be accepted on the first rising edge at which rd_en|wr_en=1.

Verification
REQ-030 Write: wr_en=1, address=32'h0000_0010, write_data=32'hDEAD_BEEF ->
- ready=0 for 5 cycles;
- SRAM word 8 = 16'hBEEF and word 9 = 16'hDEAD;
- WE_N low for exactly 2 cycles;
- ready=1 in cycle 6.
REQ-031 Read back: rd_en=1, address=32'h0000_0010 -> read_data=32'hDEAD_BEEF when ready rises, and DQ is never driven by the controller.
REQ-032 Simultaneous request: wr_en=1 and rd_en=1, address=32'h4, write_data=32'h1234_5678 -> write performed (words 2/3 = 16'h5678/16'h1234) and read_data unchanged.
REQ-033 Back-to-back: rd_en held high for 12 cycles -> two complete accesses, ready pattern 0,0,0,0,0,1,0,0,0,0,0,1.
REQ-034 Reset mid-write: rst=0 during HIGH -> WE_N=1 and DQ=Z in the same cycle, state IDLE, read_data=0, and no further SRAM_ADDR activity.
REQ-035 Wrap: read at address=32'h0008_0008 -> SRAM_ADDR 18'd4 then 18'd5.
